// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/memory-stage requesters, the arbiter and the backing memory.
// The slave modport is the arbiter's view; the master modport is the requester-plus-memory side.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_ack;
  logic [63:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        d_err;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        f_stall_mem;
  logic        m_stall_mem;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output f_stall_mem, m_stall_mem
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  f_stall_mem, m_stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port backing memory between instruction fetch and the data stage, with
// starvation-bounded data priority, address bounds checking and a backend response timeout.
module mem_port_arbiter #(
    parameter int MEM_SIZE   = 256,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic [1:0]          dbg_state
);

    // Handshakes: a requester holds req and its fields stable until the single-cycle ack; the
    // backend holds mem_req until mem_ready is sampled high, then answers with one mem_rvalid.

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [63:0]   MAX_ADDR   = 64'(MEM_SIZE - 8);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic          owner_q;        // 1 = data stage owns the access
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;

    logic          mem_req_q, mem_req_d;
    logic          mem_we_q;
    logic [63:0]   mem_addr_q, mem_wdata_q;

    logic          i_ack_q, i_err_q, d_ack_q, d_err_q;
    logic [63:0]   i_rdata_q, d_rdata_q;

    logic          grant_d, grant_i;
    logic [63:0]   sel_addr, sel_wdata;
    logic          sel_we;
    logic          resp_load, resp_err, resp_to_d;
    logic [63:0]   resp_rdata;

    assign tmo_inc = tmo_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        mem_req_d  = mem_req_q;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_we     = 1'b0;
        resp_load  = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        resp_to_d  = owner_q;

        case (state_q)
            S_IDLE: begin
                // Data wins ties unless fetch has already waited through STARVE_MAX data grants.
                if (bus.d_req && !(bus.i_req && starve_q == STARVE_LIM)) begin
                    grant_d = 1'b1;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                end

                if (grant_d) begin
                    sel_addr  = bus.d_addr;
                    sel_we    = bus.d_we;
                    sel_wdata = bus.d_wdata;
                    if (!bus.i_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + SW'(1);
                    end
                end else if (grant_i) begin
                    sel_addr = bus.i_addr;
                    starve_d = '0;
                end

                resp_to_d = grant_d;
                if (grant_d || grant_i) begin
                    if (sel_addr > MAX_ADDR) begin
                        state_d   = S_RESP;
                        resp_load = 1'b1;
                        resp_err  = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        mem_req_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    resp_load  = 1'b1;
                    resp_rdata = mem_we_q ? 64'd0 : bus.mem_rdata;
                    state_d    = S_RESP;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIM) begin
                        resp_load = 1'b1;
                        resp_err  = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Acks are loaded on the transition into RESP so they are high exactly while in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            mem_req_q <= mem_req_d;

            if (grant_d || grant_i) begin
                owner_q     <= grant_d;
                mem_we_q    <= sel_we;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end

            i_ack_q <= resp_load && !resp_to_d;
            d_ack_q <= resp_load && resp_to_d;

            if (resp_load) begin
                if (resp_to_d) begin
                    d_err_q   <= resp_err;
                    d_rdata_q <= resp_rdata;
                end else begin
                    i_err_q   <= resp_err;
                    i_rdata_q <= resp_rdata;
                end
            end
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.i_ack       = i_ack_q;
    assign bus.i_err       = i_err_q;
    assign bus.i_rdata     = i_rdata_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.d_err       = d_err_q;
    assign bus.d_rdata     = d_rdata_q;

    // Combinational so a requester freezes in the same cycle it raises req.
    assign bus.f_stall_mem = bus.i_req & ~i_ack_q;
    assign bus.m_stall_mem = bus.d_req & ~d_ack_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, latency, arbitration order, bounds, timeout and
// reset-mid-access, with hand-computed expectations and a small auto-responding backend.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_SIZE  (256),
    .STARVE_MAX(4),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // backend: when be_auto, answers each accepted request with rvalid one cycle later
  logic be_auto, be_force, be_fire;
  always @(posedge clk) begin
    be_fire = be_auto && bus.mem_req && bus.mem_ready;
    #1;
    bus.mem_rvalid = be_force || be_fire;
  end

  // observations gathered by xfer
  logic        seen_req, seen_we, other_ack, stall_ok;
  logic [63:0] seen_addr, seen_wdata;

  // driver: issue one request at a negedge and wait (bounded) for its ack
  task automatic xfer(input logic is_d, input logic we, input logic [63:0] addr,
                      input logic [63:0] wdata, output int lat, output logic err,
                      output logic [63:0] rdata);
    logic ack, oth, stl, done;
    seen_req = 1'b0; seen_we = 1'b0; seen_addr = '0; seen_wdata = '0;
    other_ack = 1'b0; stall_ok = 1'b1;
    lat = 0; err = 1'b0; rdata = '0; done = 1'b0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    #1;
    stl = is_d ? bus.m_stall_mem : bus.f_stall_mem;
    if (!stl) stall_ok = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      lat++;
      ack = is_d ? bus.d_ack : bus.i_ack;
      oth = is_d ? bus.i_ack : bus.d_ack;
      stl = is_d ? bus.m_stall_mem : bus.f_stall_mem;
      if (oth) other_ack = 1'b1;
      if (bus.mem_req && !seen_req) begin
        seen_req = 1'b1; seen_we = bus.mem_we;
        seen_addr = bus.mem_addr; seen_wdata = bus.mem_wdata;
      end
      if (ack) begin
        done  = 1'b1;
        err   = is_d ? bus.d_err : bus.i_err;
        rdata = is_d ? bus.d_rdata : bus.i_rdata;
        if (stl) stall_ok = 1'b0;
      end else if (!stl) begin
        stall_ok = 1'b0;
      end
    end
    if (!done) lat = -1;
    if (is_d) bus.d_req = 1'b0;
    else      bus.i_req = 1'b0;
  endtask

  // scoreboard for the arbitration order (1 = data, 0 = fetch)
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];

  int          lat;
  logic        err;
  logic [63:0] rdata;

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 64'd8;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd16; bus.d_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    be_auto = 1'b0; be_force = 1'b0;

    // --- reset with both requests held
    repeat (3) @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_i_ack", 64'(bus.i_ack), 64'd0);
    check("rst_d_ack", 64'(bus.d_ack), 64'd0);
    check("rst_errs", {62'd0, bus.i_err, bus.d_err}, 64'd0);
    check("rst_rdata", bus.i_rdata | bus.d_rdata, 64'd0);
    check("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    check("rst_mem_fields", bus.mem_addr | bus.mem_wdata | 64'(bus.mem_we), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant_state", 64'(dbg_state), 64'd1);
    check("post_rst_mem_req", 64'(bus.mem_req), 64'd1);
    check("post_rst_mem_addr", bus.mem_addr, 64'd16);
    @(negedge clk);
    check("issue_hold_req", 64'(bus.mem_req), 64'd1);
    check("issue_hold_addr", bus.mem_addr, 64'd16);
    bus.mem_ready = 1'b1; be_auto = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_0000_1111;
    xfer(1'b1, 1'b0, 64'd16, 64'd0, lat, err, rdata);
    check("first_d_rdata", rdata, 64'hDEAD_BEEF_0000_1111);
    check("first_d_other_ack", 64'(other_ack), 64'd0);
    // the held fetch is granted right after
    bus.mem_rdata = 64'h0000_0000_1234_5678;
    xfer(1'b0, 1'b0, 64'd8, 64'd0, lat, err, rdata);
    check("held_i_rdata", rdata, 64'h0000_0000_1234_5678);
    @(negedge clk);

    // --- best-case fetch read
    bus.mem_rdata = 64'h30F4_0A00_0000_0000;
    xfer(1'b0, 1'b0, 64'd8, 64'd0, lat, err, rdata);
    check("fetch_latency", 64'(lat), 64'd3);
    check("fetch_rdata", rdata, 64'h30F4_0A00_0000_0000);
    check("fetch_err", 64'(err), 64'd0);
    check("fetch_stall", 64'(stall_ok), 64'd1);
    check("fetch_mem_addr", seen_addr, 64'd8);
    check("fetch_no_d_ack", 64'(other_ack), 64'd0);
    @(negedge clk);

    // --- data write in range
    bus.mem_rdata = 64'hFFFF_0000_FFFF_0000;
    xfer(1'b1, 1'b1, 64'd248, 64'hA5A5_5A5A_0F0F_F0F0, lat, err, rdata);
    check("wr_latency", 64'(lat), 64'd3);
    check("wr_mem_we", 64'(seen_we), 64'd1);
    check("wr_mem_wdata", seen_wdata, 64'hA5A5_5A5A_0F0F_F0F0);
    check("wr_rdata_zero", rdata, 64'd0);
    check("wr_stall", 64'(stall_ok), 64'd1);
    @(negedge clk);

    // --- both requesting continuously: D D D D I D
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.mem_rdata = 64'h11;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd64;
    bus.i_req = 1'b1; bus.i_addr = 64'd0;
    for (int c = 0; c < 200 && got_q.size() < 6; c++) begin
      @(negedge clk);
      if (bus.d_ack) got_q.push_back(1'b1);
      if (bus.i_ack) got_q.push_back(1'b0);
      if (bus.d_ack && bus.i_ack) check("dual_ack", 64'd1, 64'd0);
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    check("grant_count", 64'(got_q.size()), 64'd6);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check($sformatf("grant_order_%0d", 6 - exp_q.size()), 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    @(negedge clk);

    // --- timeout: backend accepts but never answers
    be_auto = 1'b0;
    xfer(1'b1, 1'b0, 64'd40, 64'd0, lat, err, rdata);
    check("tmo_latency", 64'(lat), 64'(2 + TIMEOUT));
    check("tmo_err", 64'(err), 64'd1);
    check("tmo_rdata", rdata, 64'd0);
    be_force = 1'b1;
    repeat (3) @(negedge clk);
    check("late_rvalid_state", 64'(dbg_state), 64'd0);
    check("late_rvalid_ack", {62'd0, bus.i_ack, bus.d_ack}, 64'd0);
    be_force = 1'b0;
    @(negedge clk);

    // --- bounds errors
    be_auto = 1'b1;
    xfer(1'b1, 1'b1, 64'd250, 64'h77, lat, err, rdata);
    check("oob_latency", 64'(lat), 64'd1);
    check("oob_err", 64'(err), 64'd1);
    check("oob_rdata", rdata, 64'd0);
    check("oob_no_mem_req", 64'(seen_req), 64'd0);
    @(negedge clk);
    xfer(1'b0, 1'b0, 64'h8000_0000_0000_0010, 64'd0, lat, err, rdata);
    check("oob_high_err", 64'(err), 64'd1);
    check("oob_high_no_mem_req", 64'(seen_req), 64'd0);
    @(negedge clk);
    bus.mem_rdata = 64'h0BAD_F00D_0000_0248;
    xfer(1'b0, 1'b0, 64'd248, 64'd0, lat, err, rdata);
    check("edge_addr_mem_req", 64'(seen_req), 64'd1);
    check("edge_addr_err", 64'(err), 64'd0);
    check("edge_addr_rdata", rdata, 64'h0BAD_F00D_0000_0248);
    @(negedge clk);

    // --- reset while in WAIT, then a pending fetch is serviced
    be_auto = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'd32;
    for (int c = 0; c < 10 && dbg_state != 2'd2; c++) @(negedge clk);
    check("reach_wait", 64'(dbg_state), 64'd2);
    bus.i_req = 1'b1; bus.i_addr = 64'd96;
    rst = 1'b1; bus.d_req = 1'b0;
    @(negedge clk);
    check("wait_rst_state", 64'(dbg_state), 64'd0);
    check("wait_rst_no_ack", {62'd0, bus.i_ack, bus.d_ack}, 64'd0);
    check("wait_rst_mem_req", 64'(bus.mem_req), 64'd0);
    rst = 1'b0; be_auto = 1'b1; bus.mem_rdata = 64'h9696;
    xfer(1'b0, 1'b0, 64'd96, 64'd0, lat, err, rdata);
    check("after_rst_latency", 64'(lat), 64'd3);
    check("after_rst_rdata", rdata, 64'h9696);
    check("after_rst_err", 64'(err), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
